// File: rtl/handshake_fifo.sv
// Req/ack handshake FIFO: consumes pulsed words from an upstream producer and
// re-issues them as single-cycle ack pulses to a downstream sink, in order.
module handshake_fifo #(
  parameter int data_width = 32,
  parameter int depth      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    req_l,
  input  logic                    ack_l,
  input  logic [data_width-1:0]   din_l,
  input  logic                    req_r,
  output logic                    ack_r,
  output logic [data_width-1:0]   dout_r,
  output logic [$clog2(depth):0]  level,
  output logic [31:0]             count_in,
  output logic [31:0]             count_out,
  output logic                    ovf
);

  localparam int ptr_w   = $clog2(depth);
  localparam int level_w = ptr_w + 1;

  localparam logic [level_w-1:0] full_level = level_w'(depth);
  localparam logic [level_w-1:0] req_limit  = level_w'(depth - 2);
  localparam logic [level_w-1:0] level_one  = level_w'(1);
  localparam logic [ptr_w-1:0]   ptr_one    = ptr_w'(1);

  logic [data_width-1:0] mem [depth];
  logic [ptr_w-1:0]      wr_ptr;
  logic [ptr_w-1:0]      rd_ptr;
  logic                  push;
  logic                  pop;
  logic                  accept;
  logic [level_w-1:0]    level_next;

  // A full buffer still takes a word when a pop frees a slot on the same edge.
  always_comb begin
    push       = ack_l;
    pop        = req_r & ~ack_r & (level != '0);
    accept     = push & ((level != full_level) | pop);
    level_next = level;
    if (accept && !pop) begin
      level_next = level + level_one;
    end else if (!accept && pop) begin
      level_next = level - level_one;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr] <= din_l;
    end
  end

  // Request more only while two slots remain, so a producer acking once per
  // sampled request can never overrun the buffer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_l     <= 1'b0;
      ack_r     <= 1'b0;
      dout_r    <= '0;
      level     <= '0;
      count_in  <= '0;
      count_out <= '0;
      ovf       <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else begin
      level <= level_next;
      req_l <= (level_next <= req_limit);
      ack_r <= pop;
      if (accept) begin
        wr_ptr   <= wr_ptr + ptr_one;
        count_in <= count_in + 32'd1;
      end
      if (push && !accept) begin
        ovf <= 1'b1;
      end
      if (pop) begin
        dout_r    <= mem[rd_ptr];
        rd_ptr    <= rd_ptr + ptr_one;
        count_out <= count_out + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_handshake_fifo.sv
// Scoreboard bench for handshake_fifo: stimulus queues expected words, a monitor
// checks each downstream ack against the queue head.
module tb_handshake_fifo;

  localparam int data_width = 32;
  localparam int depth      = 4;
  localparam int level_w    = $clog2(depth) + 1;

  logic                  clk;
  logic                  rst;
  logic                  req_l;
  logic                  ack_l;
  logic [data_width-1:0] din_l;
  logic                  req_r;
  logic                  ack_r;
  logic [data_width-1:0] dout_r;
  logic [level_w-1:0]    level;
  logic [31:0]           count_in;
  logic [31:0]           count_out;
  logic                  ovf;

  typedef struct {
    logic [31:0] data;
    int          edge_no;
  } entry_t;

  entry_t      exp_q[$];
  entry_t      mon_e;
  int          checks;
  int          passes;
  int          edge_no;
  bit          prev_ack;
  bit          last_ack;
  bit          exp_ovf;
  bit          seen_dead;
  int          next_word;
  logic [31:0] oldest;

  handshake_fifo #(
    .data_width(data_width),
    .depth     (depth)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_l    (req_l),
    .ack_l    (ack_l),
    .din_l    (din_l),
    .req_r    (req_r),
    .ack_r    (ack_r),
    .dout_r   (dout_r),
    .level    (level),
    .count_in (count_in),
    .count_out(count_out),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Called at a negedge; checks occupancy, drives one cycle of inputs and
  // records the word in the scoreboard if the buffer has room (or a pop is
  // known to coincide), then advances to the next negedge.
  task automatic applyStimulus(input bit ack, input logic [31:0] data,
                               input bit rreq, input bit pop_sure);
    entry_t e;
    checkOutput("level", 32'(level), 32'(exp_q.size()));
    ack_l    = ack;
    din_l    = data;
    req_r    = rreq;
    last_ack = ack;
    if (ack) begin
      if (exp_q.size() < depth || pop_sure) begin
        e.data    = data;
        e.edge_no = edge_no + 1;
        exp_q.push_back(e);
      end else begin
        exp_ovf = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  // Compliant producer: acks only on a sampled request, never back-to-back.
  task automatic produce(input int prob, input bit rreq);
    bit a;
    a = req_l && !last_ack && ($urandom_range(99) < prob);
    applyStimulus(a, next_word, rreq, 1'b0);
    if (a) next_word++;
  endtask

  task automatic doReset();
    #2 rst = 1'b0;
    #1;
    checkOutput("rst_req_l", 32'(req_l), 32'd0);
    checkOutput("rst_ack_r", 32'(ack_r), 32'd0);
    checkOutput("rst_dout_r", dout_r, 32'd0);
    checkOutput("rst_level", 32'(level), 32'd0);
    checkOutput("rst_count_in", count_in, 32'd0);
    checkOutput("rst_count_out", count_out, 32'd0);
    checkOutput("rst_ovf", 32'(ovf), 32'd0);
    exp_q.delete();
    exp_ovf  = 1'b0;
    ack_l    = 1'b0;
    req_r    = 1'b0;
    din_l    = '0;
    last_ack = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    checkOutput("req_l_before_edge", 32'(req_l), 32'd0);
    @(posedge clk);
    #1 checkOutput("req_l_after_release", 32'(req_l), 32'd1);
    @(negedge clk);
  endtask

  // Monitor: every downstream ack must match the oldest queued word, come at
  // least one edge after its acceptance, and never follow another ack.
  always begin
    @(posedge clk);
    edge_no++;
    #1;
    if (rst && ack_r) begin
      checkOutput("ack_gap", 32'(prev_ack), 32'd0);
      if (exp_q.size() == 0) begin
        checkOutput("ack_while_empty", 32'(ack_r), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("dout_r", dout_r, mon_e.data);
        checkOutput("latency", 32'(edge_no > mon_e.edge_no), 32'd1);
      end
      if (dout_r == 32'hDEAD) seen_dead = 1'b1;
    end
    prev_ack = ack_r;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst   = 1'b1;
    ack_l = 1'b0;
    req_r = 1'b0;
    din_l = '0;
    doReset();

    // Fill with the sink stalled.
    next_word = 0;
    for (int i = 0; i < 20; i++) produce(100, 1'b0);
    checkOutput("fill_level", 32'(level), 32'd3);
    checkOutput("fill_req_l", 32'(req_l), 32'd0);
    checkOutput("fill_ovf", 32'(ovf), 32'd0);
    checkOutput("fill_count_in", count_in, 32'd3);

    // Drain while sourcing up to word 19.
    for (int i = 0; i < 400 && !(next_word >= 20 && exp_q.size() == 0); i++)
      produce((next_word < 20) ? 100 : 0, 1'b1);
    checkOutput("drain_count_in", count_in, 32'd20);
    checkOutput("drain_count_out", count_out, 32'd20);
    checkOutput("drain_level", 32'(level), 32'd0);

    // Simultaneous push and pop at level 3.
    for (int i = 0; i < 50 && exp_q.size() < 3; i++) produce(100, 1'b0);
    checkOutput("simul_fill", 32'(level), 32'd3);
    oldest = 32'd20;
    applyStimulus(1'b1, next_word, 1'b1, 1'b1);
    next_word++;
    checkOutput("simul_ack", 32'(ack_r), 32'd1);
    checkOutput("simul_oldest", dout_r, oldest);
    checkOutput("simul_level", 32'(level), 32'd3);
    for (int i = 0; i < 50 && exp_q.size() > 0; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("simul_count_out", count_out, 32'd24);

    // Reset mid-stream with two words held.
    for (int i = 0; i < 50 && exp_q.size() < 2; i++) produce(100, 1'b0);
    checkOutput("rst_pre_level", 32'(level), 32'd2);
    doReset();

    // Overflow: ack every other cycle regardless of req_l.
    next_word = 100;
    for (int i = 0; i < 20 && exp_q.size() < depth; i++) begin
      applyStimulus(1'b1, next_word, 1'b0, 1'b0);
      next_word++;
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
    end
    applyStimulus(1'b1, 32'hDEAD, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("ovf_flag", 32'(ovf), 32'(exp_ovf));
    checkOutput("ovf_set", 32'(ovf), 32'd1);
    checkOutput("ovf_level", 32'(level), 32'd4);
    checkOutput("ovf_count_in", count_in, 32'd4);
    applyStimulus(1'b1, 32'h0BEE, 1'b1, 1'b1);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("full_pop_push_count_in", count_in, 32'd5);
    checkOutput("full_pop_push_level", 32'(level), 32'd4);
    for (int i = 0; i < 50 && exp_q.size() > 0; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("ovf_count_out", count_out, 32'd5);
    checkOutput("ovf_sticky", 32'(ovf), 32'd1);
    checkOutput("dead_delivered", 32'(seen_dead), 32'd0);

    // Random traffic with 30% downstream stalls.
    doReset();
    next_word = 0;
    for (int i = 0; i < 40000 && next_word < 5000; i++)
      produce(60, $urandom_range(99) >= 30);
    for (int i = 0; i < 100 && exp_q.size() > 0; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("rand_count_in", count_in, 32'd5000);
    checkOutput("rand_count_out", count_out, 32'd5000);
    checkOutput("rand_ovf", 32'(ovf), 32'd0);
    checkOutput("rand_level", 32'(level), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
